// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-ported program memory between instruction fetch and data load/store.
// Each granted access runs LATENCY memory cycles and finishes with one registered acknowledge pulse.
module imem_port_arbiter #(
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter int unsigned TEXT_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [31:0] TEXT_BYTES = 32'(TEXT_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 1 = data port owns the transaction
  logic            last_q, last_d;     // 1 = data port was granted last
  logic [31:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            grant_data;
  logic [31:0]     req_addr;
  logic [31:0]     text_off;
  logic            req_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      cnt_q   <= {CW{1'b0}};
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Round-robin on a tie; the bounds check wraps addresses below TEXT_BASE to large offsets.
  always_comb begin
    grant_data = (if_req && d_req) ? ~last_q : d_req;
    req_addr   = grant_data ? d_addr : if_addr;
    text_off   = req_addr - TEXT_BASE;
    req_err    = (req_addr[1:0] != 2'b00) || (!grant_data && (text_off >= TEXT_BYTES));

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          owner_d = grant_data;
          last_d  = grant_data;
          addr_d  = req_addr;
          we_d    = grant_data & d_we;
          wdata_d = grant_data ? d_wdata : 32'd0;
          rdata_d = 32'd0;
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          state_d = req_err ? S_RESP : S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_q == {CW{1'b0}}) begin
          rdata_d = we_q ? 32'd0 : mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_en    = (state_q == S_ACCESS);
    mem_we    = (state_q == S_ACCESS) && we_q;
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q;
    if_ack    = (state_q == S_RESP) && !owner_q;
    d_ack     = (state_q == S_RESP) && owner_q;
    if_rdata  = if_ack ? rdata_q : 32'd0;
    if_err    = if_ack && err_q;
    d_rdata   = d_ack ? rdata_q : 32'd0;
    d_err     = d_ack && err_q;
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed-vector bench for imem_port_arbiter (LATENCY=2); outputs sampled 1 time unit after each rising edge.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, if_err, d_ack, d_err, mem_en, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  imem_port_arbiter #(.LATENCY(2), .TEXT_BASE(32'h0000_3000), .TEXT_WORDS(128)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Reset asserted in the middle of an access
    d_req = 1'b1; d_addr = 32'h0000_3040;
    tick();
    chk("pre_rst_mem_en", {31'd0, mem_en}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_mem_addr", mem_addr, 32'd0);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // Basic fetch, capture of mem_rdata in the last access cycle
    if_req = 1'b1; if_addr = 32'h0000_3000; mem_rdata = 32'h1111_1111;
    tick();
    chk("f_c1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("f_c1_mem_addr", mem_addr, 32'h0000_3000);
    chk("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("f_c1_ack", {31'd0, if_ack}, 32'd0);
    tick();
    mem_rdata = 32'h2222_2222;
    chk("f_c2_mem_en", {31'd0, mem_en}, 32'd1);
    tick();
    chk("f_c3_if_ack", {31'd0, if_ack}, 32'd1);
    chk("f_c3_if_rdata", if_rdata, 32'h2222_2222);
    chk("f_c3_if_err", {31'd0, if_err}, 32'd0);
    chk("f_c3_mem_en", {31'd0, mem_en}, 32'd0);
    chk("f_c3_d_ack", {31'd0, d_ack}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("f_c4_if_ack", {31'd0, if_ack}, 32'd0);
    chk("f_c4_busy", {31'd0, busy}, 32'd0);

    // Contention: last grant was fetch, so data wins this tie
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h0000_3004; d_addr = 32'h0000_3100; d_we = 1'b0;
    mem_rdata = 32'hBBBB_0002;
    tick();
    chk("t1_mem_addr", mem_addr, 32'h0000_3100);
    tick(); tick();
    chk("t1_d_ack", {31'd0, d_ack}, 32'd1);
    chk("t1_d_rdata", d_rdata, 32'hBBBB_0002);
    chk("t1_if_ack", {31'd0, if_ack}, 32'd0);
    chk("t1_if_rdata", if_rdata, 32'd0);
    d_req = 1'b0;
    mem_rdata = 32'hAAAA_0001;
    tick();
    chk("t1_idle_gap", {31'd0, busy}, 32'd0);
    tick();
    chk("t1_fetch_next", mem_addr, 32'h0000_3004);
    tick(); tick();
    chk("t1_if_ack_after", {31'd0, if_ack}, 32'd1);
    chk("t1_if_rdata_after", if_rdata, 32'hAAAA_0001);
    if_req = 1'b0;
    tick();

    // Fresh reset: first tie goes to fetch, data follows with ack 4 cycles later, then fetch wins again
    rst = 1'b0; #1; rst = 1'b1;
    tick();
    if_req = 1'b1; d_req = 1'b1; mem_rdata = 32'hAAAA_0003;
    tick();
    chk("t2_fetch_first", mem_addr, 32'h0000_3004);
    tick(); tick();
    chk("t2_if_ack", {31'd0, if_ack}, 32'd1);
    chk("t2_d_ack_lo", {31'd0, d_ack}, 32'd0);
    if_req = 1'b0; mem_rdata = 32'hBBBB_0004;
    tick(); tick();
    chk("t2_data_addr", mem_addr, 32'h0000_3100);
    tick(); tick();
    chk("t2_d_ack_plus4", {31'd0, d_ack}, 32'd1);
    chk("t2_d_rdata", d_rdata, 32'hBBBB_0004);
    d_req = 1'b0;
    tick();
    if_req = 1'b1; d_req = 1'b1;
    tick();
    chk("t3_fetch_wins", mem_addr, 32'h0000_3004);
    tick(); tick();
    chk("t3_if_ack", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t3_d_ack", {31'd0, d_ack}, 32'd1);
    d_req = 1'b0;
    tick();

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_3010; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_5555;
    tick();
    chk("st_c1_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    chk("st_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_c1_addr", mem_addr, 32'h0000_3010);
    tick();
    chk("st_c2_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    tick();
    chk("st_d_ack", {31'd0, d_ack}, 32'd1);
    chk("st_d_rdata", d_rdata, 32'd0);
    chk("st_d_err", {31'd0, d_err}, 32'd0);
    chk("st_resp_we", {31'd0, mem_we}, 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Errors: misaligned, past end of text, below text base, misaligned data
    if_req = 1'b1; if_addr = 32'h0000_3002;
    tick();
    chk("e1_ack_err", {30'd0, if_ack, if_err}, 32'd3);
    chk("e1_rdata", if_rdata, 32'd0);
    chk("e1_mem_en", {31'd0, mem_en}, 32'd0);
    if_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_3200;
    tick();
    chk("e2_ack_err", {30'd0, if_ack, if_err}, 32'd3);
    chk("e2_mem_en", {31'd0, mem_en}, 32'd0);
    if_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_2FFC;
    tick();
    chk("e3_ack_err", {30'd0, if_ack, if_err}, 32'd3);
    chk("e3_mem_en", {31'd0, mem_en}, 32'd0);
    if_req = 1'b0;
    tick();
    if_req = 1'b1; if_addr = 32'h0000_31FC;
    tick();
    chk("e4_last_word_ok", {30'd0, mem_en, if_ack}, 32'd2);
    if_req = 1'b0;
    tick(); tick();
    chk("e4_no_err", {30'd0, if_ack, if_err}, 32'd2);
    tick();
    d_req = 1'b1; d_addr = 32'h0000_0001;
    tick();
    chk("e5_d_ack_err", {30'd0, d_ack, d_err}, 32'd3);
    chk("e5_if_ack", {31'd0, if_ack}, 32'd0);
    d_req = 1'b0;
    tick();

    // Dropped request still completes
    d_req = 1'b1; d_addr = 32'h0000_3020; mem_rdata = 32'h7777_0007;
    tick();
    d_req = 1'b0;
    tick(); tick();
    chk("drop_d_ack", {31'd0, d_ack}, 32'd1);
    chk("drop_d_rdata", d_rdata, 32'h7777_0007);
    tick();

    // Held fetch request restarts the cycle after RESP
    if_req = 1'b1; if_addr = 32'h0000_3008;
    tick(); tick(); tick();
    chk("hold_ack", {31'd0, if_ack}, 32'd1);
    tick();
    chk("hold_gap", {30'd0, busy, mem_en}, 32'd0);
    tick();
    chk("hold_restart", {31'd0, mem_en}, 32'd1);
    chk("hold_addr", mem_addr, 32'h0000_3008);
    if_req = 1'b0;
    tick(); tick(); tick();
    chk("end_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
